// File: rtl/rst_mgr_pkg.sv
// Shared encodings for the multi-channel reset manager.
// Channel modes, channel FSM states and status-word bit positions.
package rst_mgr_pkg;

    localparam logic [1:0] MODE_OFF        = 2'b00;
    localparam logic [1:0] MODE_CONT       = 2'b01;
    localparam logic [1:0] MODE_TRIG_LEVEL = 2'b10;
    localparam logic [1:0] MODE_TRIG_EDGE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } ch_state_e;

    localparam int STAT_TRIG    = 8;
    localparam int STAT_WD      = 9;
    localparam int STAT_INST    = 10;
    localparam int STAT_FAULT   = 11;
    localparam int STAT_FNOW    = 12;
    localparam int STAT_CNT_LSB = 16;

    localparam logic [31:0] WD_CNT_MAX    = 32'hFFFF_FFFF;
    localparam logic [15:0] FAULT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rst_mgr_channel.sv
// One reset channel: run-mode FSM with a registered copy of its mode
// so that any reconfiguration forces the channel back through IDLE.
module rst_mgr_channel
    import rst_mgr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_i,
    input  logic       trig_s_i,
    input  logic       trig_rise_i,
    input  logic       inst_i,
    input  logic       fault_i,
    output logic       aresetn_o
);

    ch_state_e  state_q, state_d;
    logic [1:0] mode_q;
    logic       aresetn_q;

    always_comb begin
        state_d = state_q;
        if (inst_i) begin
            state_d = ST_IDLE;
        end else if (fault_i) begin
            state_d = ST_FAULT;
        end else if (mode_i != mode_q) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mode_i == MODE_CONT)
                        state_d = ST_RUN;
                    else if (mode_i == MODE_TRIG_LEVEL && trig_s_i)
                        state_d = ST_RUN;
                    else if (mode_i == MODE_TRIG_EDGE)
                        state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_rise_i)
                        state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (mode_i == MODE_OFF)
                        state_d = ST_IDLE;
                    else if (mode_i == MODE_TRIG_LEVEL && !trig_s_i)
                        state_d = ST_IDLE;
                end
                ST_FAULT: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output is registered alongside the state so it never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_OFF;
            aresetn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_i;
            aresetn_q <= (state_d == ST_RUN);
        end
    end

    assign aresetn_o = aresetn_q;

endmodule

// File: rtl/reset_manager_multi.sv
// Multi-channel peripheral reset manager: pin synchronisers, watchdog
// with sticky fault and event counter, heartbeat and status word.
module reset_manager_multi
    import rst_mgr_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int ALIVE_LOW_CYCLES  = 12500000,
    parameter int ALIVE_HIGH_CYCLES = 1250000
) (
    input  logic                  clk,
    input  logic                  peripheral_reset,
    input  logic [2*NUM_CH-1:0]   cfg_mode,
    input  logic [NUM_CH-1:0]     cfg_wd_en,
    input  logic [31:0]           cfg_wd_timeout,
    input  logic                  fault_clear,
    input  logic                  trigger_in,
    input  logic                  watchdog_in,
    input  logic                  instant_reset_in,
    output logic [NUM_CH-1:0]     ch_aresetn,
    output logic                  reset_ack,
    output logic                  alive_signal,
    output logic [31:0]           status
);

    localparam logic [31:0] ALIVE_LOW  = 32'(ALIVE_LOW_CYCLES);
    localparam logic [31:0] ALIVE_LAST =
        32'(ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES - 1);

    logic [2:0]             sync_q [SYNC_STAGES];
    logic [1:0]             dly_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   trig_s, wd_s, inst_s;
    logic                   edges_ok, trig_rise, wd_edge;

    assign trig_s = sync_q[SYNC_STAGES-1][0];
    assign wd_s   = sync_q[SYNC_STAGES-1][1];
    assign inst_s = sync_q[SYNC_STAGES-1][2];

    // Edges are only trusted once the delayed copy holds a real pin
    // sample; otherwise a pin already high at reset looks like a rise.
    assign edges_ok  = fill_q[SYNC_STAGES];
    assign trig_rise = edges_ok & trig_s & ~dly_q[0];
    assign wd_edge   = edges_ok & (wd_s ^ dly_q[1]);

    always_ff @(posedge clk or posedge peripheral_reset) begin
        if (peripheral_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            dly_q  <= '0;
            fill_q <= '0;
        end else begin
            sync_q[0] <= {instant_reset_in, watchdog_in, trigger_in};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            dly_q  <= {wd_s, trig_s};
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        wd_fault_q, wd_fault_d;
    logic [15:0] fault_cnt_q, fault_cnt_d;
    logic        fault_now, fault_set;

    assign fault_now = (cfg_wd_timeout != 32'd0) &&
                       (wd_cnt_q >= cfg_wd_timeout);
    assign fault_set = fault_now & (|cfg_wd_en);

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (wd_edge)
            wd_cnt_d = 32'd0;
        else if (wd_cnt_q != WD_CNT_MAX)
            wd_cnt_d = wd_cnt_q + 32'd1;

        wd_fault_d = wd_fault_q;
        if (fault_set)
            wd_fault_d = 1'b1;
        else if (fault_clear)
            wd_fault_d = 1'b0;

        fault_cnt_d = fault_cnt_q;
        if (fault_set && !wd_fault_q && fault_cnt_q != FAULT_CNT_MAX)
            fault_cnt_d = fault_cnt_q + 16'd1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rst_mgr_channel u_ch (
            .clk         (clk),
            .rst         (peripheral_reset),
            .mode_i      (cfg_mode[2*g +: 2]),
            .trig_s_i    (trig_s),
            .trig_rise_i (trig_rise),
            .inst_i      (inst_s),
            .fault_i     (wd_fault_q & cfg_wd_en[g]),
            .aresetn_o   (ch_aresetn[g])
        );
    end

    logic [31:0] alive_cnt_q, alive_cnt_d;
    logic        alive_q;
    logic        reset_ack_q;
    logic [31:0] status_q, status_d;

    always_comb begin
        alive_cnt_d = (alive_cnt_q == ALIVE_LAST) ? 32'd0
                                                   : alive_cnt_q + 32'd1;

        status_d                  = '0;
        status_d[NUM_CH-1:0]      = ch_aresetn;
        status_d[STAT_TRIG]       = trig_s;
        status_d[STAT_WD]         = wd_s;
        status_d[STAT_INST]       = inst_s;
        status_d[STAT_FAULT]      = wd_fault_q;
        status_d[STAT_FNOW]       = fault_now;
        status_d[STAT_CNT_LSB +: 16] = fault_cnt_q;
    end

    always_ff @(posedge clk or posedge peripheral_reset) begin
        if (peripheral_reset) begin
            wd_cnt_q    <= '0;
            wd_fault_q  <= 1'b0;
            fault_cnt_q <= '0;
            alive_cnt_q <= '0;
            alive_q     <= 1'b0;
            reset_ack_q <= 1'b0;
            status_q    <= '0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            wd_fault_q  <= wd_fault_d;
            fault_cnt_q <= fault_cnt_d;
            alive_cnt_q <= alive_cnt_d;
            alive_q     <= (alive_cnt_q >= ALIVE_LOW);
            reset_ack_q <= inst_s | wd_fault_q;
            status_q    <= status_d;
        end
    end

    assign reset_ack    = reset_ack_q;
    assign alive_signal = alive_q;
    assign status       = status_q;

endmodule
